// File: rtl/v_alu_wb_buffer_pkg.sv
// v_alu_wb_buffer_pkg: shared vALU writeback constants and the result-entry type.
package v_alu_wb_buffer_pkg;

    localparam int VWB_DATA_WIDTH = 64;
    localparam int VWB_ADDR_WIDTH = 5;
    localparam int VWB_DEPTH      = 8;

    typedef struct packed {
        logic [VWB_ADDR_WIDTH-1:0] addr;
        logic [VWB_DATA_WIDTH-1:0] data;
    } vwb_entry_t;

endpackage

// File: rtl/v_alu_wb_buffer_fifo.sv
// v_wb_fifo: generic synchronous FIFO; a pop frees room for a same-cycle push when full.
module v_wb_fifo #(
    parameter int WIDTH     = 69,
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic [PTR_WIDTH:0]   count,
    output logic                 full,
    output logic                 empty
);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0]   count_q, count_d;
    logic                 do_push, do_pop;

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(do_pop);
        wr_ptr_d = wr_ptr_q + PTR_WIDTH'(do_push);
        count_d  = count_q + (PTR_WIDTH+1)'(do_push) - (PTR_WIDTH+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = count_q == (PTR_WIDTH+1)'(DEPTH);
    assign empty = count_q == '0;

endmodule

// File: rtl/v_alu_wb_buffer.sv
// v_alu_wb_buffer: credit-guarded result buffer between vALU pipelines and the VRF write port.
// Define VWB_OVERFLOW_CHK_EN to build the sticky err checker (drops and credit underflow).
module v_alu_wb_buffer
    import v_alu_wb_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = VWB_DATA_WIDTH,
    parameter int ADDR_WIDTH = VWB_ADDR_WIDTH,
    parameter int DEPTH      = VWB_DEPTH,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [DATA_WIDTH-1:0] in_vec,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic                  err
);

    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic [EW-1:0]        fifo_dout;
    logic [PTR_WIDTH:0]   count, inflight_q, inflight_d;
    logic [PTR_WIDTH+1:0] credits_used;
    logic                 fifo_full, fifo_empty, pop, issue_fire, in_sat;

    v_wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .din   ({in_addr, in_vec}),
        .dout  (fifo_dout),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wb_valid           = !fifo_empty;
    assign pop                = wb_valid && wb_ready;
    assign {wb_addr, wb_data} = fifo_dout;

    // Credits count buffered plus in-flight results so every launch has a slot waiting.
    always_comb begin
        credits_used = {1'b0, count} + {1'b0, inflight_q};
        issue_ready  = !fifo_full && (credits_used < (PTR_WIDTH+2)'(DEPTH));
        issue_fire   = issue_valid && issue_ready;
        in_sat       = in_valid && (inflight_q == '0);
        inflight_d   = (issue_fire && !in_valid) ? inflight_q + (PTR_WIDTH+1)'(1) :
                       (in_valid && !issue_fire && !in_sat) ? inflight_q - (PTR_WIDTH+1)'(1) :
                       inflight_q;
    end

    always_ff @(posedge clk) begin
        inflight_q <= rst ? '0 : inflight_d;
    end

`ifdef VWB_OVERFLOW_CHK_EN
    logic err_q, err_d, drop;

    always_comb begin
        drop  = in_valid && fifo_full && !pop;
        err_d = err_q || drop || in_sat;
    end

    always_ff @(posedge clk) begin
        err_q <= rst ? 1'b0 : err_d;
`ifndef SYNTHESIS
        if (!rst && drop) $error("v_alu_wb_buffer: result dropped, buffer full");
        if (!rst && in_sat) $error("v_alu_wb_buffer: result arrived with no credit in flight");
`endif
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
